// File: rtl/fifo_param_pkg.sv
// Shared constants for the parametrised FIFO: state encodings and state width.
package fifo_param_pkg;
    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] INIT     = 3'b000;
    localparam logic [STATE_W-1:0] WRITE    = 3'b001;
    localparam logic [STATE_W-1:0] WR_ERROR = 3'b010;
    localparam logic [STATE_W-1:0] READ     = 3'b011;
    localparam logic [STATE_W-1:0] RD_ERROR = 3'b100;
    localparam logic [STATE_W-1:0] NO_OP    = 3'b101;
    localparam logic [STATE_W-1:0] WR_RD    = 3'b110;
endpackage

// File: rtl/fifo_param_ns.sv
// Next-state function of the FIFO controller; the chosen state also decides
// which accesses are performed in the same edge.
module fifo_param_ns
    import fifo_param_pkg::*;
#(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [STATE_W-1:0]    state,
    input  logic [ADDR_WIDTH:0]   data_count,
    output logic [STATE_W-1:0]    next_state
);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);

    logic full, empty;
    assign full  = (data_count == DEPTH_C);
    assign empty = (data_count == '0);

    always_comb begin
        next_state = INIT;
        if (state == 3'b111) begin
            next_state = INIT;
        end else begin
            unique case ({wr_en, rd_en})
                2'b10: next_state = full  ? WR_ERROR : WRITE;
                2'b01: next_state = empty ? RD_ERROR : READ;
                // Both requested: degrade to the single access that is legal
                2'b11: next_state = empty ? WRITE : (full ? READ : WR_RD);
                default: next_state = (state == INIT && empty) ? INIT : NO_OP;
            endcase
        end
    end
endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with state reporting, threshold flags and
// per-request ack/err pulses.
module fifo_param
    import fifo_param_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [ADDR_WIDTH:0]   data_count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err,
    output logic [STATE_W-1:0]    state
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [STATE_W-1:0]    next_state;
    logic                  do_wr, do_rd;

    fifo_param_ns #(.ADDR_WIDTH(ADDR_WIDTH)) u_ns (
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .state      (state),
        .data_count (data_count),
        .next_state (next_state)
    );

    assign do_wr = (next_state == WRITE) || (next_state == WR_RD);
    assign do_rd = (next_state == READ)  || (next_state == WR_RD);

    assign full         = (data_count == DEPTH_C);
    assign empty        = (data_count == '0);
    assign almost_full  = (data_count >= AF_C);
    assign almost_empty = (data_count <= AE_C);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= INIT;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_count <= '0;
            dout       <= '0;
            wr_ack     <= 1'b0;
            wr_err     <= 1'b0;
            rd_ack     <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            state  <= next_state;
            wr_ack <= do_wr;
            wr_err <= wr_en && !do_wr;
            rd_ack <= do_rd;
            rd_err <= rd_en && !do_rd;
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_wr, do_rd})
                2'b10:   data_count <= data_count + 1'b1;
                2'b01:   data_count <= data_count - 1'b1;
                default: data_count <= data_count;
            endcase
        end
    end

    // Storage is never cleared; reset only blocks a write in the same cycle
    always_ff @(posedge clk) begin
        if (!reset && do_wr) mem[wr_ptr] <= din;
    end
endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param (DEPTH=8, 8-bit data) with hand-computed expectations.
module tb_fifo_param;
    logic       clk = 1'b0;
    logic       reset, wr_en, rd_en;
    logic [7:0] din, dout;
    logic [3:0] data_count;
    logic       full, empty, almost_full, almost_empty;
    logic       wr_ack, wr_err, rd_ack, rd_err;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .din(din),
        .dout(dout), .data_count(data_count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive a request at the falling edge, sample 1 time unit after the rising edge
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        @(negedge clk);
        wr_en = w; rd_en = r; din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_count", 32'(data_count), 32'd0);
        chk("rst_dout", 32'(dout), 32'h00);
        chk("rst_flags", {28'd0, empty, full, almost_empty, almost_full}, 32'b1010);
        chk("rst_ackerr", {28'd0, wr_ack, wr_err, rd_ack, rd_err}, 32'b0000);
        @(negedge clk); reset = 1'b0;

        // Fill
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 8'(i * 8'h11));
            chk("fill_state", 32'(state), 32'd1);
            chk("fill_ack", 32'(wr_ack), 32'd1);
            chk("fill_count", 32'(data_count), 32'(i));
            chk("fill_af", 32'(almost_full), 32'(i >= 6));
            chk("fill_ae", 32'(almost_empty), 32'(i <= 2));
            chk("fill_full", 32'(full), 32'(i == 8));
        end

        step(1'b1, 1'b0, 8'h99);
        chk("ovf_state", 32'(state), 32'd2);
        chk("ovf_err", {30'd0, wr_err, wr_ack}, 32'b10);
        chk("ovf_count", 32'(data_count), 32'd8);

        // Drain; 0x99 must not have been stored anywhere
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk("drain_dout", 32'(dout), 32'(8'(i * 8'h11)));
            chk("drain_state", 32'(state), 32'd3);
            chk("drain_ack", 32'(rd_ack), 32'd1);
        end
        chk("drain_empty", 32'(empty), 32'd1);

        step(1'b0, 1'b1, 8'h00);
        chk("udf_state", 32'(state), 32'd4);
        chk("udf_err", {30'd0, rd_err, rd_ack}, 32'b10);
        chk("udf_dout", 32'(dout), 32'h88);
        chk("udf_count", 32'(data_count), 32'd0);

        step(1'b0, 1'b0, 8'h00);
        chk("idle_state", 32'(state), 32'd5);
        chk("idle_pulses", {28'd0, wr_ack, wr_err, rd_ack, rd_err}, 32'b0000);
        chk("idle_dout", 32'(dout), 32'h88);

        // Pointer wrap
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hA0 + i));
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk("wrap1_dout", 32'(dout), 32'(8'(8'hA0 + i)));
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'hB0 + i));
        chk("wrap2_count", 32'(data_count), 32'd6);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk("wrap2_dout", 32'(dout), 32'(8'(8'hB0 + i)));
        end
        chk("wrap_count0", 32'(data_count), 32'd0);

        // Simultaneous read/write at count 3
        step(1'b1, 1'b0, 8'hC1);
        step(1'b1, 1'b0, 8'hC2);
        step(1'b1, 1'b0, 8'hC3);
        begin
            logic [7:0] exp_wr [4];
            exp_wr[0] = 8'hC1; exp_wr[1] = 8'hC2; exp_wr[2] = 8'hC3; exp_wr[3] = 8'hD1;
            for (int i = 0; i < 4; i++) begin
                step(1'b1, 1'b1, 8'(8'hD1 + i));
                chk("wrrd_state", 32'(state), 32'd6);
                chk("wrrd_count", 32'(data_count), 32'd3);
                chk("wrrd_dout", 32'(dout), 32'(exp_wr[i]));
                chk("wrrd_acks", {28'd0, wr_ack, wr_err, rd_ack, rd_err}, 32'b1010);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk("wrrd_tail", 32'(dout), 32'(8'(8'hD2 + i)));
        end
        chk("wrrd_empty", 32'(empty), 32'd1);

        // Both requested while empty
        step(1'b1, 1'b1, 8'hE1);
        chk("be_state", 32'(state), 32'd1);
        chk("be_acks", {28'd0, wr_ack, wr_err, rd_ack, rd_err}, 32'b1001);
        chk("be_count", 32'(data_count), 32'd1);
        chk("be_dout", 32'(dout), 32'hD4);
        step(1'b0, 1'b1, 8'h00);
        chk("be_read", 32'(dout), 32'hE1);

        // Both requested while full
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'hF0 + i));
        step(1'b1, 1'b1, 8'h55);
        chk("bf_state", 32'(state), 32'd3);
        chk("bf_acks", {28'd0, wr_ack, wr_err, rd_ack, rd_err}, 32'b0110);
        chk("bf_count", 32'(data_count), 32'd7);
        chk("bf_dout", 32'(dout), 32'hF0);

        // Mid-operation reset at count 5 with a write pending
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        chk("pre_rst_count", 32'(data_count), 32'd5);
        @(negedge clk);
        reset = 1'b1; wr_en = 1'b1; rd_en = 1'b0; din = 8'h77;
        @(posedge clk);
        #1;
        chk("mrst_state", 32'(state), 32'd0);
        chk("mrst_count", 32'(data_count), 32'd0);
        chk("mrst_empty", 32'(empty), 32'd1);
        chk("mrst_dout", 32'(dout), 32'h00);
        chk("mrst_wr_ack", 32'(wr_ack), 32'd0);
        @(negedge clk);
        reset = 1'b0; wr_en = 1'b0;
        step(1'b0, 1'b0, 8'h00);
        chk("post_rst_init", 32'(state), 32'd0);
        step(1'b0, 1'b1, 8'h00);
        chk("post_rst_rderr", {29'd0, state}, 32'd4);
        chk("post_rst_rd_err", 32'(rd_err), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
